// File: rtl/div16_pkg.sv
// Shared widths, saturation limits, FSM encoding and the sign/saturation
// helper for the Q9.8 / Q1.7 restoring divider.
package div16_pkg;

    localparam int W_DVD   = 17;
    localparam int W_DSR   = 8;
    localparam int FRAC_SH = 7;
    localparam int W_INT   = 24;
    localparam int W_CNT   = 5;

    localparam logic [W_DVD-1:0] SAT_POS = 17'h0FFFF;
    localparam logic [W_DVD-1:0] SAT_NEG = 17'h10000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [W_DVD-1:0] val;
        logic             ovf;
    } fix_t;

    // Apply the result sign to an unsigned quotient and clamp to 17 bits.
    function automatic fix_t sign_fix(input logic [W_INT-1:0] mag,
                                      input logic             neg);
        fix_t r;
        r.val = '0;
        r.ovf = 1'b0;
        if (neg) begin
            if (mag > {{(W_INT-W_DVD){1'b0}}, SAT_NEG}) begin
                r.val = SAT_NEG;
                r.ovf = 1'b1;
            end else begin
                r.val = ~mag[W_DVD-1:0] + 1'b1;
            end
        end else begin
            if (mag > {{(W_INT-W_DVD){1'b0}}, SAT_POS}) begin
                r.val = SAT_POS;
                r.ovf = 1'b1;
            end else begin
                r.val = mag[W_DVD-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/div16_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div16_step
    import div16_pkg::*;
(
    input  logic [W_DSR-1:0] rem,
    input  logic             bit_in,
    input  logic [W_DSR-1:0] dsr,
    output logic [W_DSR-1:0] rem_nxt,
    output logic             q
);

    logic [W_DSR:0] sh;

    assign sh = {rem, bit_in};
    assign q  = (sh >= {1'b0, dsr});

    // The kept remainder is always below dsr, so 8-bit wraparound is exact.
    assign rem_nxt = q ? (sh[W_DSR-1:0] - dsr) : sh[W_DSR-1:0];

endmodule

// File: rtl/div16.sv
// Signed Q9.8 / Q1.7 divider, one quotient bit per cycle on magnitudes,
// with registered sign fix, saturation and divide-by-zero handling.
module div16
    import div16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_DVD-1:0] in_17bit,
    input  logic [W_DSR-1:0] in_8bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_DVD-1:0] out,
    output logic             ovf,
    output logic             div_zero
);

    state_t state;
    state_t nxt;

    logic [W_INT-1:0] dvd;
    logic [W_INT-1:0] quo;
    logic [W_DSR-1:0] rem;
    logic [W_DSR-1:0] rem_nxt;
    logic [W_DSR-1:0] dsr;
    logic [W_CNT-1:0] cnt;
    logic             neg;
    logic             a_neg;
    logic             dz;
    logic             q_bit;

    logic [W_DVD-1:0] a_mag;
    logic [W_DSR-1:0] b_mag;
    logic             b_zero;
    fix_t             fix;

    assign in_ready = (state == IDLE);
    assign a_mag    = in_17bit[W_DVD-1] ? (~in_17bit + 1'b1) : in_17bit;
    assign b_mag    = in_8bit[W_DSR-1] ? (~in_8bit + 1'b1) : in_8bit;
    assign b_zero   = (in_8bit == '0);
    assign fix      = sign_fix(quo, neg);

    div16_step u_step (
        .rem     (rem),
        .bit_in  (dvd[W_INT-1]),
        .dsr     (dsr),
        .rem_nxt (rem_nxt),
        .q       (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (in_valid) nxt = b_zero ? DONE : CALC;
            CALC: if (cnt == '0) nxt = DONE;
            DONE: if (out_valid && out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd       <= '0;
            quo       <= '0;
            rem       <= '0;
            dsr       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            a_neg     <= 1'b0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd   <= {a_mag, {FRAC_SH{1'b0}}};
                        dsr   <= b_mag;
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= W_CNT'(W_INT - 1);
                        neg   <= in_17bit[W_DVD-1] ^ in_8bit[W_DSR-1];
                        a_neg <= in_17bit[W_DVD-1];
                        dz    <= b_zero;
                    end
                end
                CALC: begin
                    dvd <= dvd << 1;
                    rem <= rem_nxt;
                    quo <= {quo[W_INT-2:0], q_bit};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                DONE: begin
                    // First DONE cycle registers the final result.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        if (dz) begin
                            out      <= a_neg ? SAT_NEG : SAT_POS;
                            ovf      <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            out      <= fix.val;
                            ovf      <= fix.ovf;
                            div_zero <= 1'b0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div16.md
DIV16 -- requirements
Module: div16

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  operand pair valid.
REQ-004 in_ready  output  1  block can accept operands (high only in IDLE).
REQ-005 in_17bit  input  17  dividend, signed two's complement, 9 integer . 8 fraction bits.
REQ-006 in_8bit  input  8  divisor, signed two's complement Q1.7 (e.g. 8'hC0 = -0.5).
REQ-007 out_valid  output  1  result valid, held until accepted.
REQ-008 out_ready  input  1  downstream accepts result.
REQ-009 out  output  17  quotient, same format as in_17bit.
REQ-010 ovf  output  1  quotient saturated; qualified by out_valid.
REQ-011 div_zero  output  1  divisor was zero; qualified by out_valid.

Function
REQ-012 Result SHALL be the inverse of the butterfly multiplier scaling: out = trunc_toward_zero((in_17bit * 2^7) / in_8bit), a 24-bit intermediate.
REQ-013 Division SHALL be restoring, on magnitudes: 24-bit |dividend|<<7, 8-bit |divisor| (|-128| = 128 is legal), one quotient bit per cycle, MSB first.
REQ-014 Result sign SHALL be sign(in_17bit) XOR sign(in_8bit); a zero quotient SHALL be +0.
REQ-015 Results outside [-65536, 65535] SHALL saturate to 17'h0FFFF or 17'h10000 with ovf=1; otherwise ovf=0.
REQ-016 FSM states: IDLE, CALC, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready at edge k, operands are latched; go to CALC (or DONE if divisor zero).
REQ-018 CALC: 5-bit iteration counter runs 23 down to 0; after the 24th iteration (edge k+24), go to DONE; sign fix and saturation are registered on entry to DONE, so out_valid=1 after edge k+25.
REQ-019 Divisor zero: skip CALC; out_valid=1 after edge k+1; div_zero=1, ovf=1; out = 17'h0FFFF if dividend >= 0, else 17'h10000.
REQ-020 DONE: out, ovf, div_zero held stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1 at an edge: return to IDLE; out_valid=0 the next cycle; no same-cycle new accept (in_ready low in DONE).
REQ-022 in_valid outside IDLE SHALL be ignored; operand changes during CALC SHALL not affect the result.
REQ-023 Throughput: one division per 26 cycles minimum (zero-divisor: 2).

Reset
REQ-024 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, out=0, ovf=0, div_zero=0, counter=0, remainder/quotient registers=0.
REQ-025 Reset during CALC or DONE SHALL abort the operation with no result emitted; first accept is possible at the first edge after rst deasserts.

Structure
REQ-026 Shared package: operand widths (17, 8), fraction shift (7), intermediate width (24), saturation limits 17'h0FFFF / 17'h10000, FSM state encoding.
REQ-027 One sub-module, div16_step: combinational single restoring step (remainder, divisor -> new remainder, quotient bit); FSM, counter, and sign/saturation logic stay in div16.

Verification
REQ-028 in_17bit=17'h1FF00 (-1.0), in_8bit=8'hC0 (-0.5) -> out=17'h00200 (2.0), ovf=0, out_valid exactly 25 cycles after the accept edge.
REQ-029 in_17bit=17'h00001, in_8bit=8'h03 -> out=17'h0002A; in_17bit=17'h1FFFF, in_8bit=8'h03 -> out=17'h1FFD6 (truncation toward zero).
REQ-030 in_17bit=17'h0FF00, in_8bit=8'h01 -> out=17'h0FFFF, ovf=1; in_17bit=17'h10000, in_8bit=8'h80 -> out=17'h0FFFF, ovf=1.
REQ-031 in_8bit=8'h00 with in_17bit=17'h1FF00 -> out=17'h10000, div_zero=1, ovf=1, out_valid one cycle after accept.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out/flags stable, in_ready=0; in_valid pulses ignored; accept on out_ready=1 -> IDLE.
REQ-033 Assert rst at iteration 12 of CALC -> out_valid never rises; a subsequent 17'h00100 / 8'h40 -> out=17'h00200.
